// File: rtl/dac_spi_rx_pkg.sv
// Shared types and frame layout for the DAC serial receiver.
// Frame: [15] AB, [14] BUF, [13] GA_b, [12] SHDN_b, [11:0] code, shifted MSB first.
package dac_spi_rx_pkg;

   localparam int unsigned FrameW   = 16;
   localparam int unsigned DataW    = 12;
   localparam int unsigned BitAb    = 15;
   localparam int unsigned BitBuf   = 14;
   localparam int unsigned BitGaB   = 13;
   localparam int unsigned BitShdnB = 12;

   localparam int unsigned CntW = 5;
   localparam logic [CntW-1:0] CntSat = CntW'(FrameW + 1);

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StCheck
   } state_e;

   function automatic logic frame_ok(input logic [CntW-1:0]   cnt,
                                     input logic [FrameW-1:0] w1,
                                     input logic [FrameW-1:0] w2);
      return (cnt == CntW'(FrameW)) && !w1[BitAb] && !w2[BitAb];
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with a trailing edge-detect flop.
// rise_o/fall_o are single-cycle pulses, SYNC stages after the pin edge.
module sync_edge #(
   parameter int unsigned STAGES    = 2,
   parameter bit          RESET_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_n,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign rise_o = sync_q[STAGES-1] & ~prev_q;
   assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/dac_spi_rx.sv
// Receives dual-channel DAC serial frames into input registers and transfers
// them to the output latches on the falling edge of LDAC (dac_le_b).
module dac_spi_rx
   import dac_spi_rx_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_n,
   input  logic             dac_clk,
   input  logic             dac_cs_b,
   input  logic             dac_le_b,
   input  logic             dac_dat_1,
   input  logic             dac_dat_2,
   output logic [DataW-1:0] sample_1,
   output logic [DataW-1:0] sample_2,
   output logic             sample_valid,
   output logic [1:0]       shdn,
   output logic [1:0]       gain2x,
   output logic             frame_err,
   output logic [15:0]      frame_count
);

   logic clk_rise, cs_rise, cs_fall, le_fall;
   logic unused_clk_fall, unused_le_rise;

   sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_clk (
      .clk_i (clk_i), .rst_n (rst_n), .d_i (dac_clk),
      .rise_o(clk_rise), .fall_o(unused_clk_fall)
   );
   sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
      .clk_i (clk_i), .rst_n (rst_n), .d_i (dac_cs_b),
      .rise_o(cs_rise), .fall_o(cs_fall)
   );
   sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_le (
      .clk_i (clk_i), .rst_n (rst_n), .d_i (dac_le_b),
      .rise_o(unused_le_rise), .fall_o(le_fall)
   );

   // Data is delayed to line up with the synchronized dac_clk edge.
   logic [SYNC_STAGES-1:0] dat1_q, dat2_q;

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         dat1_q <= '0;
         dat2_q <= '0;
      end else begin
         dat1_q <= {dat1_q[SYNC_STAGES-2:0], dac_dat_1};
         dat2_q <= {dat2_q[SYNC_STAGES-2:0], dac_dat_2};
      end
   end

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [FrameW-1:0] sr1_q, sr1_d, sr2_q, sr2_d;
   logic [DataW-1:0]  code1_q, code1_d, code2_q, code2_d;
   logic [1:0]        in_sh_q, in_sh_d, in_ga_q, in_ga_d;
   logic              err_q, err_d;
   logic [15:0]       fcnt_q, fcnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr1_d   = sr1_q;
      sr2_d   = sr2_q;
      code1_d = code1_q;
      code2_d = code2_q;
      in_sh_d = in_sh_q;
      in_ga_d = in_ga_q;
      err_d   = err_q;
      fcnt_d  = fcnt_q;
      unique case (state_q)
         StIdle: begin
            if (cs_fall) begin
               state_d = StShift;
               cnt_d   = '0;
            end
         end
         StShift: begin
            if (clk_rise) begin
               sr1_d = {sr1_q[FrameW-2:0], dat1_q[SYNC_STAGES-1]};
               sr2_d = {sr2_q[FrameW-2:0], dat2_q[SYNC_STAGES-1]};
               cnt_d = (cnt_q == CntSat) ? cnt_q : cnt_q + 1'b1;
            end
            // The frame is judged on the cs_b rising edge so that an LDAC edge
            // arriving in the same cycle can load straight through.
            if (cs_rise) begin
               state_d = StCheck;
               if (frame_ok(cnt_d, sr1_d, sr2_d)) begin
                  code1_d = sr1_d[DataW-1:0];
                  code2_d = sr2_d[DataW-1:0];
                  in_ga_d = {~sr2_d[BitGaB], ~sr1_d[BitGaB]};
                  in_sh_d = {~sr2_d[BitShdnB], ~sr1_d[BitShdnB]};
                  fcnt_d  = fcnt_q + 16'd1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StCheck: begin
            if (cs_fall) begin
               state_d = StShift;
               cnt_d   = '0;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         sr1_q   <= '0;
         sr2_q   <= '0;
         code1_q <= '0;
         code2_q <= '0;
         in_sh_q <= '0;
         in_ga_q <= '0;
         err_q   <= 1'b0;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr1_q   <= sr1_d;
         sr2_q   <= sr2_d;
         code1_q <= code1_d;
         code2_q <= code2_d;
         in_sh_q <= in_sh_d;
         in_ga_q <= in_ga_d;
         err_q   <= err_d;
         fcnt_q  <= fcnt_d;
      end
   end

   logic [DataW-1:0] samp1_q, samp2_q;
   logic [1:0]       shdn_q, gain_q;
   logic             valid_q;

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         samp1_q <= '0;
         samp2_q <= '0;
         shdn_q  <= '0;
         gain_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= le_fall;
         if (le_fall) begin
            samp1_q <= code1_d;
            samp2_q <= code2_d;
            shdn_q  <= in_sh_d;
            gain_q  <= in_ga_d;
         end
      end
   end

   // BUF has no effect in this receiver.
   logic unused_buf;
   assign unused_buf = sr1_q[BitBuf] ^ sr2_q[BitBuf];

   assign sample_1     = shdn_q[0] ? '0 : samp1_q;
   assign sample_2     = shdn_q[1] ? '0 : samp2_q;
   assign sample_valid = valid_q;
   assign shdn         = shdn_q;
   assign gain2x       = gain_q;
   assign frame_err    = err_q;
   assign frame_count  = fcnt_q;

endmodule

// File: tb/tb_dac_spi_rx.sv
// Self-checking bench for dac_spi_rx: directed scenarios plus randomized frames
// checked against a frame-level reference model.
module tb_dac_spi_rx;

   logic        clk_i = 1'b0;
   logic        rst_n = 1'b0;
   logic        dac_clk = 1'b0;
   logic        dac_cs_b = 1'b1;
   logic        dac_le_b = 1'b1;
   logic        dac_dat_1 = 1'b0;
   logic        dac_dat_2 = 1'b0;
   logic [11:0] sample_1, sample_2;
   logic        sample_valid;
   logic [1:0]  shdn, gain2x;
   logic        frame_err;
   logic [15:0] frame_count;

   dac_spi_rx #(.SYNC_STAGES(2)) dut (
      .clk_i       (clk_i),
      .rst_n       (rst_n),
      .dac_clk     (dac_clk),
      .dac_cs_b    (dac_cs_b),
      .dac_le_b    (dac_le_b),
      .dac_dat_1   (dac_dat_1),
      .dac_dat_2   (dac_dat_2),
      .sample_1    (sample_1),
      .sample_2    (sample_2),
      .sample_valid(sample_valid),
      .shdn        (shdn),
      .gain2x      (gain2x),
      .frame_err   (frame_err),
      .frame_count (frame_count)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: input registers (m_*) and output latches (o_*).
   logic [11:0] m_c1, m_c2, o_c1, o_c2;
   logic [1:0]  m_sh, m_ga, o_sh, o_ga;
   logic        m_err;
   logic [15:0] m_cnt;

   task automatic model_reset();
      m_c1 = '0; m_c2 = '0; o_c1 = '0; o_c2 = '0;
      m_sh = '0; m_ga = '0; o_sh = '0; o_ga = '0;
      m_err = 1'b0; m_cnt = '0;
   endtask

   task automatic model_frame(input logic [15:0] w1, input logic [15:0] w2, input int n);
      if (n == 16 && !w1[15] && !w2[15]) begin
         m_c1 = w1[11:0];
         m_c2 = w2[11:0];
         m_ga = {~w2[13], ~w1[13]};
         m_sh = {~w2[12], ~w1[12]};
         m_cnt = m_cnt + 16'd1;
      end else begin
         m_err = 1'b1;
      end
   endtask

   task automatic model_latch();
      o_c1 = m_c1; o_c2 = m_c2; o_sh = m_sh; o_ga = m_ga;
   endtask

   function automatic logic [11:0] exp_s1();
      return o_sh[0] ? 12'h000 : o_c1;
   endfunction

   function automatic logic [11:0] exp_s2();
      return o_sh[1] ? 12'h000 : o_c2;
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic send_bits(input logic [15:0] w1, input logic [15:0] w2, input int n);
      dac_cs_b = 1'b0;
      wait_cyc(4);
      for (int i = 0; i < n; i++) begin
         int idx = 15 - (i % 16);
         dac_clk = 1'b0;
         dac_dat_1 = w1[idx];
         dac_dat_2 = w2[idx];
         wait_cyc(3);
         dac_clk = 1'b1;
         wait_cyc(3);
      end
      dac_clk = 1'b0;
      wait_cyc(3);
   endtask

   task automatic end_frame();
      dac_cs_b = 1'b1;
      wait_cyc(8);
   endtask

   task automatic send_frame(input logic [15:0] w1, input logic [15:0] w2, input int n);
      send_bits(w1, w2, n);
      end_frame();
      model_frame(w1, w2, n);
   endtask

   // Pulse LDAC (optionally together with cs_b rising) and capture outputs on valid.
   task automatic do_latch(input bit with_cs, output int nvalid,
                           output logic [11:0] s1, output logic [11:0] s2,
                           output logic [1:0] sh, output logic [1:0] ga);
      nvalid = 0;
      s1 = 'x; s2 = 'x; sh = 'x; ga = 'x;
      if (with_cs) dac_cs_b = 1'b1;
      dac_le_b = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk_i);
         #1;
         if (sample_valid === 1'b1) begin
            nvalid++;
            s1 = sample_1; s2 = sample_2; sh = shdn; ga = gain2x;
         end
      end
      dac_le_b = 1'b1;
      wait_cyc(6);
   endtask

   task automatic test_reset();
      n_checks++;
      if ({sample_1, sample_2, sample_valid, shdn, gain2x, frame_err, frame_count} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got s1=%h s2=%h v=%b sh=%b ga=%b err=%b cnt=%0d, want all zero",
                  sample_1, sample_2, sample_valid, shdn, gain2x, frame_err, frame_count);
      end
   endtask

   task automatic check_latch(input string name, input int nv, input logic [11:0] s1,
                              input logic [11:0] s2, input logic [1:0] sh, input logic [1:0] ga);
      n_checks++;
      if (nv !== 1) begin
         n_fail++; $display("FAIL %s_valid_pulses: got %0d want 1", name, nv);
      end
      n_checks++;
      if (s1 !== exp_s1() || s2 !== exp_s2()) begin
         n_fail++;
         $display("FAIL %s_samples: got %h/%h want %h/%h", name, s1, s2, exp_s1(), exp_s2());
      end
      n_checks++;
      if (sh !== o_sh || ga !== o_ga) begin
         n_fail++;
         $display("FAIL %s_cfg: got shdn=%b gain=%b want shdn=%b gain=%b", name, sh, ga, o_sh, o_ga);
      end
      n_checks++;
      if (frame_err !== m_err || frame_count !== m_cnt) begin
         n_fail++;
         $display("FAIL %s_status: got err=%b cnt=%0d want err=%b cnt=%0d",
                  name, frame_err, frame_count, m_err, m_cnt);
      end
   endtask

   task automatic test_basic();
      int nv; logic [11:0] s1, s2; logic [1:0] sh, ga;
      send_frame(16'h3ABC, 16'h3123, 16);
      do_latch(1'b0, nv, s1, s2, sh, ga);
      model_latch();
      check_latch("basic", nv, s1, s2, sh, ga);
      n_checks++;
      if (s1 !== 12'hABC || s2 !== 12'h123 || frame_count !== 16'd1) begin
         n_fail++;
         $display("FAIL basic_const: got %h/%h cnt=%0d want abc/123 cnt=1", s1, s2, frame_count);
      end
   endtask

   task automatic test_gain_shdn();
      int nv; logic [11:0] s1, s2; logic [1:0] sh, ga;
      send_frame(16'h1FFF, 16'h2800, 16);
      do_latch(1'b0, nv, s1, s2, sh, ga);
      model_latch();
      check_latch("gain_shdn", nv, s1, s2, sh, ga);
      n_checks++;
      if (s1 !== 12'hFFF || s2 !== 12'h000 || ga !== 2'b01 || sh !== 2'b10) begin
         n_fail++;
         $display("FAIL gain_shdn_const: got %h/%h ga=%b sh=%b want fff/000 ga=01 sh=10",
                  s1, s2, ga, sh);
      end
   endtask

   task automatic test_bad_frames();
      int nv; logic [11:0] s1, s2; logic [1:0] sh, ga;
      logic [15:0] cnt_before;
      cnt_before = frame_count;
      send_frame(16'h3456, 16'h3789, 15);
      send_frame(16'h3321, 16'h3654, 17);
      send_frame(16'hB111, 16'h3222, 16);
      do_latch(1'b0, nv, s1, s2, sh, ga);
      model_latch();
      check_latch("bad_frames", nv, s1, s2, sh, ga);
      n_checks++;
      if (frame_err !== 1'b1 || frame_count !== cnt_before) begin
         n_fail++;
         $display("FAIL bad_frames_const: got err=%b cnt=%0d want err=1 cnt=%0d",
                  frame_err, frame_count, cnt_before);
      end
   endtask

   task automatic test_load_through();
      int nv; logic [11:0] s1, s2; logic [1:0] sh, ga;
      send_bits(16'h3555, 16'h3AAA, 16);
      do_latch(1'b1, nv, s1, s2, sh, ga);
      model_frame(16'h3555, 16'h3AAA, 16);
      model_latch();
      check_latch("load_through", nv, s1, s2, sh, ga);
      n_checks++;
      if (s1 !== 12'h555) begin
         n_fail++; $display("FAIL load_through_const: got %h want 555", s1);
      end
   endtask

   task automatic test_random();
      int nv; logic [11:0] s1, s2; logic [1:0] sh, ga;
      for (int k = 0; k < 20; k++) begin
         logic [15:0] w1, w2;
         int n, sel;
         w1 = 16'($urandom);
         w2 = 16'($urandom);
         if ($urandom_range(0, 3) != 0) w1[15] = 1'b0;
         if ($urandom_range(0, 3) != 0) w2[15] = 1'b0;
         sel = int'($urandom_range(0, 5));
         n = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
         // dac_clk activity outside a frame must not disturb anything.
         for (int t = 0; t < 3; t++) begin
            dac_dat_1 = 1'($urandom); dac_dat_2 = 1'($urandom);
            dac_clk = 1'b1; wait_cyc(3);
            dac_clk = 1'b0; wait_cyc(3);
         end
         send_frame(w1, w2, n);
         n_checks++;
         if (frame_err !== m_err || frame_count !== m_cnt) begin
            n_fail++;
            $display("FAIL random_status[%0d]: got err=%b cnt=%0d want err=%b cnt=%0d",
                     k, frame_err, frame_count, m_err, m_cnt);
         end
         if ($urandom_range(0, 1) == 1 || k == 19) begin
            do_latch(1'b0, nv, s1, s2, sh, ga);
            model_latch();
            check_latch("random", nv, s1, s2, sh, ga);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int nv; logic [11:0] s1, s2; logic [1:0] sh, ga;
      send_bits(16'h3F0F, 16'h30F0, 8);
      rst_n = 1'b0;
      wait_cyc(2);
      model_reset();
      test_reset();
      dac_cs_b = 1'b1;
      wait_cyc(2);
      rst_n = 1'b1;
      wait_cyc(6);
      n_checks++;
      if (frame_err !== 1'b0 || frame_count !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_mid_status: got err=%b cnt=%0d want err=0 cnt=0", frame_err, frame_count);
      end
      send_frame(16'h0246, 16'h3135, 16);
      do_latch(1'b0, nv, s1, s2, sh, ga);
      model_latch();
      check_latch("after_reset", nv, s1, s2, sh, ga);
   endtask

   initial begin
      model_reset();
      wait_cyc(3);
      test_reset();
      rst_n = 1'b1;
      wait_cyc(6);
      test_reset();
      test_basic();
      test_gain_shdn();
      test_bad_frames();
      test_load_through();
      test_random();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
